// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds the FSM state type, oversampling ratio, vote-window helpers and parity encodings.
package uart_pkg;

  localparam int OSR        = 16;
  localparam int SAMPLE_MID = 8;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    BREAK
  } rx_state_t;

  // The vote window is centred on the middle sample of each bit.
  function automatic int vote_first(input int m_taps);
    return SAMPLE_MID - m_taps / 2;
  endfunction

  function automatic int vote_last(input int m_taps);
    return SAMPLE_MID + m_taps / 2;
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks.
// A reload restarts the count, so the first tick comes DIV clocks after the reload.
module uart_os_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (reload || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_mv.sv
// UART receiver with 16x oversampling and majority-vote bit decisions.
// Checks even parity and the stop bit; a low stop bit parks the receiver until the line idles.
module uart_rx_mv
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9_600,
  parameter int PARITY    = 1,
  parameter int DO_WIDTH  = 8,
  parameter int M_TAPS    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  output logic [DO_WIDTH-1:0] dout,
  output logic                dout_vld,
  output logic                err_out,
  output logic [1:0]          err_type,
  output logic                busy
);

  localparam int OS_DIV = CLK_FREQ / (BAUD_RATE * OSR);
  localparam logic [3:0] VOTE_FIRST = 4'(vote_first(M_TAPS));
  localparam logic [3:0] VOTE_LAST  = 4'(vote_last(M_TAPS));
  localparam logic [3:0] VOTE_HALF  = 4'(M_TAPS / 2);
  localparam logic [3:0] LAST_BIT   = 4'(DO_WIDTH - 1);

  logic rx_meta_q, rx_s_q;
  logic tick, reload;

  rx_state_t           state_q, state_d;
  logic [3:0]          samp_q, samp_d;
  logic [3:0]          ones_q, ones_d;
  logic [3:0]          bitcnt_q, bitcnt_d;
  logic [DO_WIDTH-1:0] sr_q, sr_d;
  logic                par_err_q, par_err_d;
  logic [DO_WIDTH-1:0] dout_q, dout_d;
  logic                dout_vld_q, dout_vld_d;
  logic                err_out_q, err_out_d;
  logic [1:0]          err_type_q, err_type_d;
  logic                busy_q, busy_d;

  logic [3:0] idx;
  logic [3:0] ones_tot;
  logic       in_win, vote, vote_now, bit_end, frm_err;

  assign reload = (state_q == IDLE) && !rx_s_q;

  uart_os_tick #(
    .DIV(OS_DIV)
  ) u_os_tick (
    .clk   (clk),
    .rst   (rst),
    .reload(reload),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    samp_d     = samp_q;
    ones_d     = ones_q;
    bitcnt_d   = bitcnt_q;
    sr_d       = sr_q;
    par_err_d  = par_err_q;
    dout_d     = dout_q;
    err_type_d = err_type_q;
    dout_vld_d = 1'b0;
    err_out_d  = 1'b0;
    frm_err    = 1'b0;

    // idx is the sample number this tick lands on; the vote includes the current sample.
    idx      = samp_q + 4'd1;
    in_win   = (idx >= VOTE_FIRST) && (idx <= VOTE_LAST);
    ones_tot = ones_q + {3'b000, in_win & rx_s_q};
    vote     = (ones_tot > VOTE_HALF);
    vote_now = tick && (idx == VOTE_LAST);
    bit_end  = tick && (idx == 4'd0);

    if ((state_q != IDLE) && tick) begin
      samp_d = idx;
      ones_d = bit_end ? 4'd0 : ones_tot;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d   = START;
          samp_d    = 4'd0;
          ones_d    = 4'd0;
          par_err_d = 1'b0;
        end
      end
      START: begin
        if (vote_now && vote) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d  = DATA;
          bitcnt_d = 4'd0;
        end
      end
      DATA: begin
        if (vote_now) begin
          sr_d = {vote, sr_q[DO_WIDTH-1:1]};
        end
        if (bit_end) begin
          if (bitcnt_q == LAST_BIT) begin
            state_d = (PARITY == PARITY_EVEN) ? PAR : STOP;
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (vote_now) begin
          par_err_d = ((^sr_q) != vote);
        end
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (vote_now) begin
          frm_err = !vote;
          dout_d  = sr_q;
          if (!frm_err && !par_err_q) begin
            dout_vld_d = 1'b1;
          end else begin
            err_out_d  = 1'b1;
            err_type_d = {frm_err, par_err_q};
          end
          state_d = frm_err ? BREAK : IDLE;
        end
      end
      BREAK: begin
        if (tick && rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      samp_q     <= 4'd0;
      ones_q     <= 4'd0;
      bitcnt_q   <= 4'd0;
      sr_q       <= '0;
      par_err_q  <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      err_out_q  <= 1'b0;
      err_type_q <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      samp_q     <= samp_d;
      ones_q     <= ones_d;
      bitcnt_q   <= bitcnt_d;
      sr_q       <= sr_d;
      par_err_q  <= par_err_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      err_out_q  <= err_out_d;
      err_type_q <= err_type_d;
      busy_q     <= busy_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign err_out  = err_out_q;
  assign err_type = err_type_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_rx_mv.sv
// Self-checking bench for uart_rx_mv: directed frames plus randomized frames against a frame-level model.
module tb_uart_rx_mv;

  localparam int CLK_FREQ = 1_536_000;
  localparam int BAUD     = 9_600;
  localparam int DW       = 8;
  localparam int BIT_CLKS = 160;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx  = 1'b1;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          err_out;
  logic [1:0]    err_type;
  logic          busy;

  int testCount = 0;
  int failCount = 0;

  // What the line should have produced so far, tracked frame by frame.
  int         expVld = 0;
  int         expErr = 0;
  logic [7:0] expDout = 8'h00;
  logic [1:0] expErrType = 2'b00;

  // Pulse observations from the output side.
  int vldCount  = 0;
  int errCount  = 0;
  int bothCount = 0;

  uart_rx_mv #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD),
    .PARITY   (1),
    .DO_WIDTH (DW),
    .M_TAPS   (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .dout    (dout),
    .dout_vld(dout_vld),
    .err_out (err_out),
    .err_type(err_type),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Count pulse cycles; a one-cycle pulse per frame shows up as exactly one count.
  always @(negedge clk) begin
    if (dout_vld) vldCount++;
    if (err_out) errCount++;
    if (dout_vld && err_out) bothCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveLine(input logic v, input int clks);
    rx = v;
    repeat (clks) @(posedge clk);
  endtask

  // Frame-level model: a good frame delivers data, any fault raises an error with {stop, parity} flags.
  task automatic modelFrame(input logic [7:0] data, input bit parFlip, input bit stopBad);
    expDout = data;
    if (parFlip || stopBad) begin
      expErr++;
      expErrType = {stopBad, parFlip};
    end else begin
      expVld++;
    end
  endtask

  // Sends start, 8 data bits LSB first, even parity (optionally flipped), then the stop bit or a low period.
  task automatic applyStimulus(input logic [7:0] data, input bit parFlip, input int stopLowBits,
                               input int bitLen, input int spikeBit);
    driveLine(1'b0, bitLen);
    for (int i = 0; i < 8; i++) begin
      if (i == spikeBit) begin
        driveLine(data[i], 75);
        driveLine(~data[i], 10);
        driveLine(data[i], bitLen - 85);
      end else begin
        driveLine(data[i], bitLen);
      end
    end
    driveLine((^data) ^ parFlip, bitLen);
    if (stopLowBits > 0) driveLine(1'b0, stopLowBits * bitLen);
    else driveLine(1'b1, bitLen);
    modelFrame(data, parFlip, stopLowBits > 0);
  endtask

  task automatic checkFrame(input string tag);
    @(posedge clk);
    #1;
    checkOutput({tag, " dout"}, 32'(dout), 32'(expDout));
    checkOutput({tag, " vld_count"}, 32'(vldCount), 32'(expVld));
    checkOutput({tag, " err_count"}, 32'(errCount), 32'(expErr));
    checkOutput({tag, " err_type"}, 32'(err_type), 32'(expErrType));
    checkOutput({tag, " both_high"}, 32'(bothCount), 32'd0);
    checkOutput({tag, " busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset dout", 32'(dout), 32'd0);
    checkOutput("reset dout_vld", 32'(dout_vld), 32'd0);
    checkOutput("reset err_out", 32'(err_out), 32'd0);
    checkOutput("reset err_type", 32'(err_type), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    rst = 1'b1;
    driveLine(1'b1, 2 * BIT_CLKS);

    // Clean frame.
    applyStimulus(8'h55, 1'b0, 0, BIT_CLKS, -1);
    driveLine(1'b1, 2 * BIT_CLKS);
    checkFrame("T1");

    // Parity error only.
    applyStimulus(8'hA3, 1'b1, 0, BIT_CLKS, -1);
    driveLine(1'b1, 2 * BIT_CLKS);
    checkFrame("T2");

    // Stop bit held low: error, then stay busy until the line rises.
    applyStimulus(8'h00, 1'b0, 3, BIT_CLKS, -1);
    #1;
    checkOutput("T3 busy_while_low", 32'(busy), 32'd1);
    driveLine(1'b1, 2 * BIT_CLKS);
    checkFrame("T3a");
    applyStimulus(8'h7E, 1'b0, 0, BIT_CLKS, -1);
    driveLine(1'b1, 2 * BIT_CLKS);
    checkFrame("T3b");

    // Short glitch on an idle line.
    driveLine(1'b0, 30);
    #1;
    checkOutput("T4 busy_glitch", 32'(busy), 32'd1);
    driveLine(1'b1, BIT_CLKS);
    checkFrame("T4");

    // Single-tick spike at the centre of data bit 2 is outvoted.
    applyStimulus(8'hC9, 1'b0, 0, BIT_CLKS, 2);
    driveLine(1'b1, 2 * BIT_CLKS);
    checkFrame("T5");

    // Reset in the middle of data bit 4 abandons the frame.
    driveLine(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) driveLine(logic'((8'h3C >> i) & 8'h01), BIT_CLKS);
    driveLine(1'b1, 80);
    rst = 1'b0;
    #1;
    checkOutput("T6 rst dout", 32'(dout), 32'd0);
    checkOutput("T6 rst err_type", 32'(err_type), 32'd0);
    checkOutput("T6 rst busy", 32'(busy), 32'd0);
    checkOutput("T6 rst dout_vld", 32'(dout_vld), 32'd0);
    checkOutput("T6 rst err_out", 32'(err_out), 32'd0);
    repeat (3) @(posedge clk);
    rst = 1'b1;
    expDout    = 8'h00;
    expErrType = 2'b00;
    driveLine(1'b1, 2 * BIT_CLKS);
    checkFrame("T6 after_rst");
    applyStimulus(8'h3C, 1'b0, 0, BIT_CLKS, -1);
    driveLine(1'b1, 2 * BIT_CLKS);
    checkFrame("T6 nominal");
    applyStimulus(8'h3C, 1'b0, 0, 165, -1);
    driveLine(1'b1, 2 * BIT_CLKS);
    checkFrame("T6 slow");
    applyStimulus(8'h3C, 1'b0, 0, 155, -1);
    driveLine(1'b1, 2 * BIT_CLKS);
    checkFrame("T6 fast");

    // Randomized frames with occasional parity and stop faults and small baud skew.
    for (int n = 0; n < 12; n++) begin
      logic [7:0] data;
      bit         parFlip;
      int         stopLow;
      int         bitLen;
      data    = 8'($urandom);
      parFlip = ($urandom_range(0, 3) == 0);
      stopLow = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      bitLen  = 156 + int'($urandom_range(0, 8));
      applyStimulus(data, parFlip, stopLow, bitLen, -1);
      driveLine(1'b1, 2 * BIT_CLKS);
      checkFrame($sformatf("R%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
